// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if
// One word-wide request/response channel. The same interface type is used
// for both requester channels (A and B) and for the channel to the cache.
//   master : the side that issues requests (drives addr/wdata/bval/rd/wr
//            and receives rdata/ack/err)
//   slave  : the side that serves requests (receives the request fields
//            and drives rdata/ack/err)
// Signals:
//   addr  [ADDR_WIDTH]  request address
//   wdata [WORD_WIDTH]  write data
//   bval  [WORD_WIDTH/8] byte enables
//   rd/wr               read / write request
//   rdata [WORD_WIDTH]  read data
//   ack                 completion
//   err                 completion with error
interface cache_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 32
);
  localparam int BVAL_WIDTH = WORD_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic [BVAL_WIDTH-1:0] bval;
  logic                  rd;
  logic                  wr;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  err;

  modport master (
    output addr, wdata, bval, rd, wr,
    input  rdata, ack, err
  );

  modport slave (
    input  addr, wdata, bval, rd, wr,
    output rdata, ack, err
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
// Shares one cache port between two requesters (A and B) using round-robin
// arbitration. A transaction runs IDLE -> BUSY -> RELEASE -> IDLE. The
// winner's request fields are captured on grant, so the requesters may
// change their inputs freely while the cache access is in flight.
//
// Optional feature: define CACHE_ARB_TIMEOUT_EN to add a BUSY watchdog.
// After TIMEOUT_CYCLES BUSY cycles without sys ack, the access is dropped and
// the winner gets ack and err together. Without the macro, BUSY waits for
// the cache indefinitely and err is always 0.
//
// Ports:
//   cache_clk : clock, rising edge
//   rst       : asynchronous active-high reset
//   a_port    : requester A channel (slave side)
//   b_port    : requester B channel (slave side)
//   sys_port  : cache channel (master side); all request outputs registered
module cache_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 cache_clk,
  input  logic                 rst,
  cache_port_arbiter_if.slave  a_port,
  cache_port_arbiter_if.slave  b_port,
  cache_port_arbiter_if.master sys_port
);
  localparam int BVAL_WIDTH = WORD_WIDTH / 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic                  win_b_q, win_b_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [BVAL_WIDTH-1:0] bval_q, bval_d;
  logic                  sys_rd_q, sys_rd_d;
  logic                  sys_wr_q, sys_wr_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [WORD_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [WORD_WIDTH-1:0] b_rdata_q, b_rdata_d;
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            cnt_q, cnt_d;
  logic                  a_err_q, a_err_d;
  logic                  b_err_q, b_err_d;
`endif

  logic req_a;
  logic req_b;
  logic grant_b;
  logic op_wr;

  // Round-robin: B wins a tie only when A was granted last.
  assign req_a   = a_port.rd | a_port.wr;
  assign req_b   = b_port.rd | b_port.wr;
  assign grant_b = req_b & (~req_a | ~last_b_q);
  // wr takes precedence over rd on the same port.
  assign op_wr   = grant_b ? b_port.wr : a_port.wr;

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    win_b_d   = win_b_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bval_d    = bval_q;
    sys_rd_d  = sys_rd_q;
    sys_wr_d  = sys_wr_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef CACHE_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          state_d  = S_BUSY;
          win_b_d  = grant_b;
          last_b_d = grant_b;
          addr_d   = grant_b ? b_port.addr  : a_port.addr;
          wdata_d  = grant_b ? b_port.wdata : a_port.wdata;
          bval_d   = grant_b ? b_port.bval  : a_port.bval;
          sys_wr_d = op_wr;
          sys_rd_d = ~op_wr;
`ifdef CACHE_ARB_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end
      end

      S_BUSY: begin
        if (sys_port.ack) begin
          state_d  = S_RELEASE;
          sys_rd_d = 1'b0;
          sys_wr_d = 1'b0;
          if (win_b_q) begin
            b_ack_d = 1'b1;
            if (sys_rd_q) b_rdata_d = sys_port.rdata;
          end else begin
            a_ack_d = 1'b1;
            if (sys_rd_q) a_rdata_d = sys_port.rdata;
          end
        end
`ifdef CACHE_ARB_TIMEOUT_EN
        // Watchdog expiry: complete with error, read data untouched.
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_RELEASE;
          sys_rd_d = 1'b0;
          sys_wr_d = 1'b0;
          if (win_b_q) begin
            b_ack_d = 1'b1;
            b_err_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
            a_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        sys_rd_d = 1'b0;
        sys_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cache_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bval_q    <= '0;
      sys_rd_q  <= 1'b0;
      sys_wr_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bval_q    <= bval_d;
      sys_rd_q  <= sys_rd_d;
      sys_wr_q  <= sys_wr_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
`endif
    end
  end

  assign sys_port.addr  = addr_q;
  assign sys_port.wdata = wdata_q;
  assign sys_port.bval  = bval_q;
  assign sys_port.rd    = sys_rd_q;
  assign sys_port.wr    = sys_wr_q;

  assign a_port.rdata = a_rdata_q;
  assign a_port.ack   = a_ack_q;
  assign b_port.rdata = b_rdata_q;
  assign b_port.ack   = b_ack_q;
`ifdef CACHE_ARB_TIMEOUT_EN
  assign a_port.err   = a_err_q;
  assign b_port.err   = b_err_q;
`else
  assign a_port.err   = 1'b0;
  assign b_port.err   = 1'b0;
`endif
endmodule
